// File: rtl/mem_access_ctrl.sv
// Purpose: turns one valid/ready load/store command into level-sensitive rd/wr strobes for the 256x16 memory.
// Latency: read response RD_WAIT_CYCLES edges after accept; write response WR_PULSE_CYCLES+2 edges after accept.
// Backpressure: one command in flight; req_ready only in IDLE, response held in RSP until rsp_ready.
module mem_access_ctrl #(
  parameter int unsigned RD_WAIT_CYCLES  = 1,
  parameter int unsigned WR_PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_RSP      = 3'd5
  } state_e;

  // Counter reload values; both parameters are limited to 1..15 so they fit 4 bits.
  localparam logic [3:0] RD_CNT_INIT = 4'(RD_WAIT_CYCLES - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'(WR_PULSE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;

  logic accept;
  logic cnt_zero;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign cnt_zero = (cnt_q == 4'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk the read or write sequence, park in RSP until the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_we ? S_WR_SETUP : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_zero) begin
          state_d = S_RSP;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_zero) begin
          state_d = S_WR_HOLD;
        end
      end
      S_WR_HOLD: state_d = S_RSP;
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: address and write data load only on accept, so they are
  // settled a full cycle before mem_wr rises and stay put one cycle after it falls.
  always_comb begin
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mem_addr_d = req_addr;
          if (req_we) begin
            mem_wdata_d = req_wdata;
          end else begin
            mem_rd_d = 1'b1;
            cnt_d    = RD_CNT_INIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_zero) begin
          rsp_rdata_d = mem_rdata;
          mem_rd_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        mem_wr_d = 1'b1;
        cnt_d    = WR_CNT_INIT;
      end
      S_WR_PULSE: begin
        if (cnt_zero) begin
          mem_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; every memory-facing output comes straight from a flop so strobes are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 8'd0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rsp_rdata_q <= 16'd0;
    end else begin
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with RD_WAIT_CYCLES=1, WR_PULSE_CYCLES=2.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on rising edges.
// The memory is a read-only table so read data is known in advance.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(
    .RD_WAIT_CYCLES (1),
    .WR_PULSE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then return to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      rsp_ready = 1'($urandom);
      tick();
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0000", rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (mem_addr !== 8'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_strobes got rd=%0b wr=%0b want 0/0", mem_rd, mem_wr); end
    checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 00", mem_wdata); end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_reset got rd=%0b wr=%0b busy=%0b ready=%0b want 0/0/0/1", mem_rd, mem_wr, busy, req_ready);
      end
    end
  endtask

  task automatic test_read();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05; req_wdata = 8'h00;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h05) begin errors++; $display("FAIL read_strobe got rd=%0b addr=%h want 1/05", mem_rd, mem_addr); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL read_wait_flags got vld=%0b rdy=%0b busy=%0b want 0/0/1", rsp_valid, req_ready, busy); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL read_rsp got vld=%0b data=%h want 1/a5c3", rsp_valid, rsp_rdata); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL read_rd_drop got %0b want 0", mem_rd); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL read_handshake got vld=%0b rdy=%0b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_write();
    int wr_cycles = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h3C;
    tick();
    req_valid = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    // Observations 0..3: setup, pulse, pulse, hold.
    for (int i = 0; i < 4; i++) begin
      if (mem_wr === 1'b1) wr_cycles++;
      checks++;
      if (mem_addr !== 8'h10 || mem_wdata !== 8'h3C) begin
        errors++; $display("FAIL write_stable cyc%0d got addr=%h data=%h want 10/3c", i, mem_addr, mem_wdata);
      end
      checks++;
      if (mem_wr !== ((i == 1 || i == 2) ? 1'b1 : 1'b0) || mem_rd !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL write_seq cyc%0d got wr=%0b rd=%0b vld=%0b", i, mem_wr, mem_rd, rsp_valid);
      end
      tick();
    end
    checks++; if (wr_cycles != 2) begin errors++; $display("FAIL write_pulse_len got %0d want 2", wr_cycles); end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL write_rsp got vld=%0b data=%h want 1/a5c3", rsp_valid, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("FAIL write_idle got rdy=%0b addr=%h want 1/10", req_ready, mem_addr); end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF;
    tick();
    // Keep offering a different read; it must not be taken while busy.
    req_addr = 8'h05;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || req_ready !== 1'b0 || mem_addr !== 8'hFF) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got vld=%0b data=%h rdy=%0b addr=%h want 1/1234/0/ff", i, rsp_valid, rsp_rdata, req_ready, mem_addr);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 8'hFF || mem_rd !== 1'b0) begin errors++; $display("FAIL bp_release got vld=%0b rdy=%0b addr=%h rd=%0b want 0/1/ff/0", rsp_valid, req_ready, mem_addr, mem_rd); end
    tick();
    req_valid = 1'b0;
    checks++; if (mem_addr !== 8'h05 || mem_rd !== 1'b1) begin errors++; $display("FAIL bp_next_accept got addr=%h rd=%0b want 05/1", mem_addr, mem_rd); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL bp_next_rsp got vld=%0b data=%h want 1/a5c3", rsp_valid, rsp_rdata); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_ignored_request();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
    tick();
    // Now in RD_WAIT: offer a write that must be ignored.
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h99;
    tick();
    checks++; if (mem_wr !== 1'b0 || mem_addr !== 8'h05 || rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL ign_rdwait got wr=%0b addr=%h data=%h want 0/05/a5c3", mem_wr, mem_addr, rsp_rdata); end
    tick();
    checks++; if (mem_wr !== 1'b0 || mem_addr !== 8'h05 || mem_wdata === 8'h99) begin errors++; $display("FAIL ign_rsp got wr=%0b addr=%h wdata=%h want 0/05/not 99", mem_wr, mem_addr, mem_wdata); end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++; if (mem_addr !== 8'h05 || req_ready !== 1'b1) begin errors++; $display("FAIL ign_idle got addr=%h rdy=%0b want 05/1", mem_addr, req_ready); end
    tick();
    checks++; if (mem_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ign_no_write got wr=%0b busy=%0b want 0/0", mem_wr, busy); end
  endtask

  task automatic test_reset_mid_write();
    int saw_rsp = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h77;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rstw_pulse got wr=%0b want 1", mem_wr); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL rstw_async got wr=%0b busy=%0b rdy=%0b addr=%h want 0/0/1/00", mem_wr, busy, req_ready, mem_addr); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1 || mem_wr === 1'b1) saw_rsp++;
      tick();
    end
    checks++; if (saw_rsp != 0) begin errors++; $display("FAIL rstw_no_rsp got %0d active cycles want 0", saw_rsp); end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("FAIL rstw_read_strobe got rd=%0b addr=%h want 1/10", mem_rd, mem_addr); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL rstw_read_rsp got vld=%0b data=%h want 1/beef", rsp_valid, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstw_read_done got vld=%0b rdy=%0b want 0/1", rsp_valid, req_ready); end
  endtask

  // Strobes must never overlap while running.
  always @(negedge clk) begin
    if (rst_n && mem_rd === 1'b1 && mem_wr === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap got rd=1 wr=1 want exclusive");
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257);
    mem[8'h05] = 16'hA5C3;
    mem[8'hFF] = 16'h1234;
    mem[8'h10] = 16'hBEEF;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_ignored_request();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator for the 256-entry x16 processor memory: converts a single-request valid/ready load/store command into the memory's level-sensitive rd/wr strobes.
- Sits between the datapath (fetch/load-store) and the memory block.
- Guarantees address and write data are stable around every write strobe, so level-sensitive writes never land at a transient address.
- Captures read data after a programmable wait and returns it through a response handshake with backpressure.

Parameters:
- RD_WAIT_CYCLES, 1, cycles mem_rd is held before mem_rdata is sampled; legal range 1..15.
- WR_PULSE_CYCLES, 2, cycles mem_wr is held high; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  command present.
- req_ready  output  1  controller can accept a command.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  8  word address.
- req_wdata  input  8  write data; the memory write port is 8 bits wide.
- rsp_valid  output  1  transaction complete; rsp_rdata valid for reads.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  16  captured read data.
- busy  output  1  high in any state other than IDLE.
- mem_addr  output  8  memory address, registered.
- mem_rd  output  1  memory read enable, registered.
- mem_wr  output  1  memory write enable, registered, glitch-free.
- mem_wdata  output  8  memory write data, registered.
- mem_rdata  input  16  memory read data; combinational from mem_addr.

Behaviour:
- Single clock domain. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0, counter=0.
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, RSP.
- req_ready=1 only in IDLE. A command is accepted on any edge where req_valid && req_ready; req_valid in other states is ignored and no command is queued.
- Accept, read: load mem_addr=req_addr; set mem_rd=1; set cnt=RD_WAIT_CYCLES-1; go to RD_WAIT.
- RD_WAIT: at each edge, if cnt==0 then rsp_rdata<=mem_rdata, mem_rd<=0, go to RSP; else decrement cnt.
  - Read latency: rsp_valid rises RD_WAIT_CYCLES edges after the accept edge.
- Accept, write: load mem_addr and mem_wdata; mem_wr stays 0; go to WR_SETUP.
- WR_SETUP (1 cycle): next edge sets mem_wr=1, cnt=WR_PULSE_CYCLES-1, go to WR_PULSE.
- WR_PULSE: mem_wr stays high exactly WR_PULSE_CYCLES cycles. When cnt==0, mem_wr<=0 and go to WR_HOLD; otherwise decrement.
- WR_HOLD (1 cycle): go to RSP.
  - Write latency: rsp_valid rises WR_PULSE_CYCLES+2 edges after the accept edge.
  - rsp_rdata is unchanged by writes.
- mem_addr and mem_wdata change only on an accept edge. They hold through setup, pulse and hold, and keep their last value in IDLE.
- mem_rd and mem_wr are never high simultaneously.
- RSP: rsp_valid=1 until an edge with rsp_ready=1, then go to IDLE with rsp_valid=0.
  - A new command can be accepted no earlier than the edge after the response handshake. Minimum back-to-back read spacing is RD_WAIT_CYCLES+2 cycles.
  - rsp_rdata holds stable while rsp_valid=1 and rsp_ready=0.
- Reset asserted mid-transaction: all outputs go immediately (asynchronously) to reset values. mem_wr drops at once, the pending response is discarded, and the controller returns to IDLE.
- Address wrap: addresses are 8-bit; 0xFF is a legal address with no special handling.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> req_ready=1, all other outputs 0. Release -> idle, and no mem_rd/mem_wr without a request.
- Read: RD_WAIT_CYCLES=1, request read at addr 0x05, mem model returns 16'hA5C3 -> mem_rd high 1 cycle with mem_addr=0x05; rsp_valid 1 edge after accept with rsp_rdata=16'hA5C3.
- Write: WR_PULSE_CYCLES=2, write addr 0x10 data 0x3C -> mem_addr/mem_wdata stable for 1 setup + 2 pulse + 1 hold cycles; mem_wr high exactly 2 cycles; rsp_valid 4 edges after accept; rsp_rdata unchanged.
- Backpressure: read addr 0xFF (data 16'h1234) with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata=16'h1234 held, req_ready=0 throughout; next command is accepted only after rsp_ready=1.
- Ignored request: assert req_valid with a write to 0x20 while a read is in RD_WAIT -> no write strobe; mem_addr unchanged until the controller returns to IDLE.
- Reset mid-write: drop rst_n during WR_PULSE -> mem_wr=0 in the same cycle (async), rsp_valid never rises; after release a read to 0x10 proceeds normally.
